// File: rtl/bit_serial_pkg.sv
// rtl/bit_serial_pkg.sv - shared state encoding and defaults for the bit-serial adder
package bit_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational one-bit full adder
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first sequencer around a single full-adder cell
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry_q;
    logic             carry_out_q;
    logic [CNT_W-1:0] cnt;
    logic             cell_s;
    logic             cell_co;
    logic             accept;
    logic             last_bit;

    fa_cell u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    assign last_bit = (cnt == LAST_BIT);
    assign accept   = in_ready & in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The counter wraps to 0 on the final bit so it never exceeds WIDTH-1;
    // carry_out has its own register so it survives the next accept's carry load.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            cnt         <= '0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= carry_in;
            sum_sr  <= '0;
            cnt     <= '0;
        end else if (state == RUN) begin
            sum_sr  <= {cell_s, sum_sr[WIDTH-1:1]};
            carry_q <= cell_co;
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            if (last_bit) begin
                cnt         <= '0;
                carry_out_q <= cell_co;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign sum       = sum_sr;
    assign carry_out = carry_out_q;

endmodule
